mlp_driver: RTL
===============

# mlp_driver

Initiator and result reader for the MLP inference core. It accepts a labelled inference request and pulses the core's `start`. It then waits for `done` under a timeout, captures the ten 8-bit class scores and the one-hot `maxi` vector, and encodes the winning class. Finally it streams the scores plus a status byte to the host over a valid/ready byte channel and keeps hit/total statistics.

## Interface
- `N_CLASSES`, 10, number of output neurons (width of `maxi`)
- `SCORE_W`, 8, bits per class score (`answer` is `N_CLASSES*SCORE_W` bits)
- `TIMEOUT`, 4095, maximum WAIT cycles before abort
- `CNT_W`, 16, width of statistics counters
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  host request
- `req_label`  in  4  expected class for this request
- `req_ready`  out  1  block idle, request accepted on `req_valid && req_ready`
- `mlp_start`  out  1  one-cycle start pulse to the core
- `mlp_done`  in  1  core completion pulse
- `mlp_answer`  in  80  class scores; class k = bits [8k+7:8k]
- `mlp_maxi`  in  10  one-hot winning class
- `out_valid`  out  1  byte available
- `out_data`  out  8  score byte or status byte
- `out_last`  out  1  marks the status byte (final byte of a record)
- `out_ready`  in  1  host accepts byte
- `clear_stats`  in  1  zero both counters
- `total_cnt`  out  16  completed requests, including aborted ones
- `hit_cnt`  out  16  requests with match

## Operation
- States: IDLE, START, WAIT, STREAM, STATUS.
- IDLE: `req_ready`=1. On handshake, latch `req_label` and go to START.
- START: `mlp_start`=1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - `mlp_done`=1: capture `mlp_answer`/`mlp_maxi`, encode the class, set `match` = (class == label) && one-hot valid, go to STREAM with byte index 0.
  - Counter reaches TIMEOUT without done: set `timeout`, set class=4'hF, go to STATUS.
  - If done and the limit occur in the same cycle, done wins.
- One-hot encode: exactly one bit set → its index. Zero or more than one bit set → `onehot_err`=1, class=4'hF, match=0.
- STREAM: `out_data` = score[idx], `out_last`=0. On `out_valid && out_ready`, idx increments. After idx=N_CLASSES-1 is accepted, go to STATUS.
- STATUS: `out_data` = {timeout, onehot_err, match, 1'b0, class[3:0]}, `out_last`=1. On accept, update the counters and go to IDLE.
- Counter updates: `total_cnt`+1, and `hit_cnt`+1 if match. Both counters saturate at all-ones.
- `clear_stats` zeroes the counters. If it coincides with an update, clear wins.
- `mlp_done` outside WAIT is ignored. `req_valid` outside IDLE is ignored (`req_ready`=0).

## Timing
- Reset (`rst`=0 at an edge) forces IDLE, from any state including mid-stream. All outputs are 0 during reset, including `req_ready`, counters, `out_*` and `mlp_start`. `req_ready`=1 from the first cycle after `rst` returns high.
- A request accepted at edge T produces `mlp_start` high in cycle T+1. WAIT begins at T+2.
- `mlp_done` sampled high at edge D produces `out_valid`=1 with score 0 in cycle D+1.
- Full throughput with `out_ready` held 1: 11 bytes in 11 consecutive cycles. The status byte is accepted at edge S and `req_ready`=1 in cycle S+1.
- `out_data`/`out_last` are stable while `out_valid`=1 and `out_ready`=0. All outputs are registered.
- Timeout: with no done, STATUS is entered TIMEOUT cycles after WAIT entry. Only the status byte is emitted.

## Structure
- Package `mlp_pkg` holds:
  - the state enum;
  - `N_CLASSES`, `SCORE_W`;
  - status-byte bit positions (TIMEOUT_BIT=7, ONEHOT_ERR_BIT=6, MATCH_BIT=5);
  - `INVALID_CLASS`=4'hF.
- Sub-module `onehot_to_idx`: combinational; input 10 bits; outputs `idx[3:0]` and `valid`.

## Test plan
- Label 3, maxi=10'b0000001000, answer bytes 0x10..0x19, `out_ready`=1 → bytes 0x10..0x19, then status 0x23 with `out_last`. Counters total=1, hit=1.
- Label 2, maxi one-hot 7 → status 0x07. Counters total+1, hit unchanged.
- maxi=10'b0000000101 → status 0x4F, match=0. maxi=0 → status 0x4F.
- No `mlp_done` for TIMEOUT cycles → only status 0x8F emitted. total+1.
- `out_ready` toggled 1/0 during streaming → no byte lost or duplicated; data held while stalled.
- Additional directed cases:
  - `rst` low mid-STREAM → all outputs 0, IDLE afterwards.
  - `clear_stats` coincident with a status accept → counters 0.
  - hit_cnt preloaded to 0xFFFF (forced) stays at 0xFFFF after a further hit.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP inference driver.
// No logic beyond the status-byte packing helper.
package mlp_pkg;

    localparam int N_CLASSES = 10;
    localparam int SCORE_W   = 8;

    localparam int TIMEOUT_BIT    = 7;
    localparam int ONEHOT_ERR_BIT = 6;
    localparam int MATCH_BIT      = 5;

    localparam logic [3:0] INVALID_CLASS = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_STREAM,
        S_STATUS
    } state_t;

    function automatic logic [7:0] status_byte(
        input logic       tmo,
        input logic       oh_err,
        input logic       match,
        input logic [3:0] cls
    );
        logic [7:0] b;
        b                 = 8'h00;
        b[TIMEOUT_BIT]    = tmo;
        b[ONEHOT_ERR_BIT] = oh_err;
        b[MATCH_BIT]      = match;
        b[3:0]            = cls;
        return b;
    endfunction

endpackage

// File: rtl/mlp_driver_onehot_to_idx.sv
// One-hot to index encoder; flags zero or multiple set bits as invalid.
// Purely combinational, no backpressure.
module onehot_to_idx
    import mlp_pkg::*;
#(
    parameter int N = N_CLASSES
) (
    input  logic [N-1:0] onehot,
    output logic [3:0]   idx,
    output logic         valid
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] w_cnt;
    logic [3:0]    w_idx;

    always_comb begin
        w_cnt = '0;
        w_idx = INVALID_CLASS;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                w_cnt = w_cnt + CW'(1);
                w_idx = 4'(i);
            end
        end
        valid = (w_cnt == CW'(1));
        idx   = valid ? w_idx : INVALID_CLASS;
    end

endmodule

// File: rtl/mlp_driver.sv
// MLP core driver: start pulse, bounded wait for done, score+status byte stream, hit stats.
// Latency: start 1 cycle after request accept; first byte 1 cycle after done.
// Backpressure: out_ready stalls the stream with data held; no new request until the status byte is taken.
module mlp_driver
    import mlp_pkg::*;
#(
    parameter int N_CLASSES = mlp_pkg::N_CLASSES,
    parameter int SCORE_W   = mlp_pkg::SCORE_W,
    parameter int TIMEOUT   = 4095,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [3:0]                   req_label,
    output logic                         req_ready,
    output logic                         mlp_start,
    input  logic                         mlp_done,
    input  logic [N_CLASSES*SCORE_W-1:0] mlp_answer,
    input  logic [N_CLASSES-1:0]         mlp_maxi,
    output logic                         out_valid,
    output logic [7:0]                   out_data,
    output logic                         out_last,
    input  logic                         out_ready,
    input  logic                         clear_stats,
    output logic [CNT_W-1:0]             total_cnt,
    output logic [CNT_W-1:0]             hit_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(N_CLASSES);

    state_t                         r_state;
    logic [3:0]                     r_label;
    logic [N_CLASSES*SCORE_W-1:0]   r_answer;
    logic [3:0]                     r_class;
    logic                           r_match;
    logic                           r_oh_err;
    logic                           r_tmo;
    logic [TW-1:0]                  r_tcnt;
    logic [IW-1:0]                  r_idx;

    logic                           r_req_ready;
    logic                           r_mlp_start;
    logic                           r_out_valid;
    logic [7:0]                     r_out_data;
    logic                           r_out_last;
    logic [CNT_W-1:0]               r_total_cnt;
    logic [CNT_W-1:0]               r_hit_cnt;

    logic [3:0]                     w_oh_idx;
    logic                           w_oh_valid;

    onehot_to_idx #(.N(N_CLASSES)) u_onehot (
        .onehot (mlp_maxi),
        .idx    (w_oh_idx),
        .valid  (w_oh_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_label     <= '0;
            r_answer    <= '0;
            r_class     <= '0;
            r_match     <= 1'b0;
            r_oh_err    <= 1'b0;
            r_tmo       <= 1'b0;
            r_tcnt      <= '0;
            r_idx       <= '0;
            r_req_ready <= 1'b0;
            r_mlp_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_total_cnt <= '0;
            r_hit_cnt   <= '0;
        end else begin
            r_mlp_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_req_ready && req_valid) begin
                        r_label     <= req_label;
                        r_req_ready <= 1'b0;
                        r_mlp_start <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_START: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so it wins over a coincident timeout
                    if (mlp_done) begin
                        r_answer    <= mlp_answer >> SCORE_W;
                        r_class     <= w_oh_idx;
                        r_oh_err    <= !w_oh_valid;
                        r_match     <= w_oh_valid && (w_oh_idx == r_label);
                        r_tmo       <= 1'b0;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= 8'(mlp_answer[SCORE_W-1:0]);
                        r_out_last  <= 1'b0;
                        r_state     <= S_STREAM;
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_class     <= INVALID_CLASS;
                        r_oh_err    <= 1'b0;
                        r_match     <= 1'b0;
                        r_tmo       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_out_data  <= status_byte(1'b1, 1'b0, 1'b0, INVALID_CLASS);
                        r_out_last  <= 1'b1;
                        r_state     <= S_STATUS;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (r_idx == IW'(N_CLASSES - 1)) begin
                            r_out_data <= status_byte(r_tmo, r_oh_err, r_match, r_class);
                            r_out_last <= 1'b1;
                            r_state    <= S_STATUS;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_out_data <= 8'(r_answer[SCORE_W-1:0]);
                            r_answer   <= r_answer >> SCORE_W;
                        end
                    end
                end
                S_STATUS: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_out_data  <= '0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                        if (r_total_cnt != '1) r_total_cnt <= r_total_cnt + 1'b1;
                        if (r_match && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // a clear overrides any same-cycle counter update
            if (clear_stats) begin
                r_total_cnt <= '0;
                r_hit_cnt   <= '0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign mlp_start = r_mlp_start;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign total_cnt = r_total_cnt;
    assign hit_cnt   = r_hit_cnt;

endmodule
